extbus_responder: RTL and testbench
===================================

EXTBUS_RESPONDER -- requirements
Module: extbus_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchroniser flops on async bus strobes (legal 2..3).
REQ-002 SHALL have parameter ADDR_W, default 5, register address width.
REQ-003 SHALL have port clk  input  1  system clock (25 MHz); one clock domain.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port extbus_cs_n  input  1  async chip select, active-low.
REQ-006 SHALL have port extbus_rd_n  input  1  async read strobe, active-low.
REQ-007 SHALL have port extbus_wr_n  input  1  async write strobe, active-low.
REQ-008 SHALL have port extbus_a  input  ADDR_W  async register address.
REQ-009 SHALL have port extbus_d_in  input  8  async write data from pad.
REQ-010 SHALL have port extbus_d_out  output  8  read data to pad.
REQ-011 SHALL have port extbus_d_oe  output  1  pad output enable.
REQ-012 SHALL have port lookup_addr  output  ADDR_W  address currently presented to register file.
REQ-013 SHALL have port reg_rddata  input  8  register file data for lookup_addr, combinational, same cycle.
REQ-014 SHALL have port reg_wr  output  1  single-cycle write-commit pulse.
REQ-015 SHALL have port reg_rd_done  output  1  single-cycle read-complete pulse (side-effect trigger, e.g. DATA port auto-increment).
REQ-016 SHALL have port reg_addr  output  ADDR_W  address qualifying reg_wr / reg_rd_done.
REQ-017 SHALL have port reg_wrdata  output  8  data qualifying reg_wr.

Function
REQ-018 SHALL pass cs_n, rd_n, wr_n through SYNC_STAGES flops each; extbus_a and extbus_d_in through equal-depth pipelines so address/data stay aligned with synced strobes.
REQ-019 SHALL define sel_wr = !cs_s & !wr_s & rd_s and sel_rd = !cs_s & !rd_s & wr_s on synced signals; both strobes low together SHALL be ignored (no state change from IDLE).
REQ-020 SHALL implement FSM states IDLE, WRITE, READ.
REQ-021 IDLE: sel_wr -> WRITE; sel_rd -> READ; else stay.
REQ-022 WRITE: every cycle capture aligned address and data into holding registers; when sel_wr drops (wr_s or cs_s deasserted) -> IDLE and assert reg_wr for exactly one cycle with reg_addr/reg_wrdata = last values captured while sel_wr was true.
REQ-023 WRITE SHALL tolerate data changing during strobe-active time (data valid late in phi2); only final captured value commits.
REQ-024 READ: every cycle drive lookup_addr = aligned address, register reg_rddata into extbus_d_out; when sel_rd drops -> IDLE, pulse reg_rd_done one cycle with reg_addr = last read address; extbus_d_out SHALL then hold.
REQ-025 extbus_d_oe SHALL be combinational !extbus_cs_n & !extbus_rd_n & extbus_wr_n from raw pins, never registered, to meet bus turn-on timing.
REQ-026 reg_wr and reg_rd_done SHALL never assert in the same cycle; each bus access SHALL produce at most one pulse.
REQ-027 Latency: pulse SHALL assert exactly SYNC_STAGES+1 clk edges after the first edge sampling raw strobe (or cs_n) deasserted.
REQ-028 Back-to-back accesses separated by >=1 synced idle cycle SHALL each produce one pulse, in order.
REQ-029 Access whose synced active window is <1 cycle SHALL produce no pulse.
REQ-030 In IDLE lookup_addr SHALL hold last value; reg_addr/reg_wrdata SHALL hold between pulses.

Reset
REQ-031 On rst at clk edge: FSM -> IDLE; strobe synchronisers -> 1 (inactive); address/data pipelines, holding registers, lookup_addr, reg_addr, reg_wrdata, extbus_d_out -> 0; reg_wr, reg_rd_done -> 0.
REQ-032 rst asserted mid-access SHALL abort it with no pulse; an access still active after rst releases SHALL not produce a pulse until its strobe is seen inactive then active again.

Verification
REQ-033 Write a=5, d=0x01, 8 MHz phi2 timing, data valid 25 ns after phi2 rise -> one reg_wr, reg_addr=5, reg_wrdata=0x01, at REQ-027 latency.
REQ-034 Four consecutive writes a=4 data 0xA1,0xA2,0xA3,0xA4 -> exactly four reg_wr pulses, data in that order, no reg_rd_done.
REQ-035 Read a=4 with model returning 0xA1 for lookup_addr=4 -> extbus_d_out=0xA1 before rd_n rises, d_oe tracks raw pins, one reg_rd_done with reg_addr=4.
REQ-036 wr_n/rd_n toggled with cs_n=1 (address 0x0000) -> no pulses, d_oe=0 throughout.
REQ-037 rst pulsed while wr_n low (a=2, d=0x55) -> no reg_wr for that access; next write a=2, d=0x66 -> single reg_wr with 0x66.
REQ-038 rd_n and wr_n both low with cs_n=0 -> FSM stays IDLE, no pulses.

Source files
------------

// File: rtl/extbus_responder.sv
// extbus_responder
//   Slave-side responder for an asynchronous microprocessor-style bus
//   (chip select, read and write strobes, address, data). All bus pins are
//   brought into the clk domain through SYNC_STAGES flops. A three-state
//   FSM then turns each synchronised access into exactly one commit pulse
//   for the register file.
//
//   Pulse semantics: reg_wr and reg_rd_done are single-cycle strobes with
//   no backpressure. reg_addr (and reg_wrdata for writes) qualify a pulse in
//   the cycle it is high, and hold their values until the next pulse.
//
// Parameters
//   SYNC_STAGES  synchroniser depth on the bus pins (2..3)
//   ADDR_W       register address width
// Ports
//   clk, rst                 system clock; synchronous active-high reset
//   extbus_cs_n/rd_n/wr_n    async bus strobes (active-low)
//   extbus_a, extbus_d_in    async address and write data
//   extbus_d_out, extbus_d_oe  read data and pad output enable
//   lookup_addr, reg_rddata  register file read port (combinational data)
//   reg_wr, reg_rd_done      one-cycle write-commit / read-complete pulses
//   reg_addr, reg_wrdata     qualifiers for the pulses
//   state_dbg                current FSM state (0 idle, 1 write, 2 read)
module extbus_responder #(
   parameter int SYNC_STAGES = 2,
   parameter int ADDR_W      = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              extbus_cs_n,
   input  logic              extbus_rd_n,
   input  logic              extbus_wr_n,
   input  logic [ADDR_W-1:0] extbus_a,
   input  logic [7:0]        extbus_d_in,
   output logic [7:0]        extbus_d_out,
   output logic              extbus_d_oe,
   output logic [ADDR_W-1:0] lookup_addr,
   input  logic [7:0]        reg_rddata,
   output logic              reg_wr,
   output logic              reg_rd_done,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [7:0]        reg_wrdata,
   output logic [1:0]        state_dbg
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2
   } state_t;

   state_t state;

   logic [SYNC_STAGES-1:0] cs_sync;
   logic [SYNC_STAGES-1:0] rd_sync;
   logic [SYNC_STAGES-1:0] wr_sync;
   // Tracks which synchroniser stages hold real pin samples rather than
   // reset values, so an access straddling reset is not mistaken for a
   // fresh one.
   logic [SYNC_STAGES-1:0] vld_sync;
   logic [ADDR_W-1:0]      a_pipe [SYNC_STAGES];
   logic [7:0]             d_pipe [SYNC_STAGES];

   logic              cs_s, rd_s, wr_s, vld_s;
   logic [ADDR_W-1:0] a_s;
   logic [7:0]        d_s;
   logic              sel_wr, sel_rd, bus_idle_s;
   logic              armed;
   logic [ADDR_W-1:0] hold_a;
   logic [7:0]        hold_d;

   // Output enable must follow the raw pins to meet bus turn-on timing.
   assign extbus_d_oe = !extbus_cs_n & !extbus_rd_n & extbus_wr_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         cs_sync  <= '1;
         rd_sync  <= '1;
         wr_sync  <= '1;
         vld_sync <= '0;
         for (int i = 0; i < SYNC_STAGES; i++) begin
            a_pipe[i] <= '0;
            d_pipe[i] <= '0;
         end
      end else begin
         cs_sync  <= {cs_sync[SYNC_STAGES-2:0], extbus_cs_n};
         rd_sync  <= {rd_sync[SYNC_STAGES-2:0], extbus_rd_n};
         wr_sync  <= {wr_sync[SYNC_STAGES-2:0], extbus_wr_n};
         vld_sync <= {vld_sync[SYNC_STAGES-2:0], 1'b1};
         a_pipe[0] <= extbus_a;
         d_pipe[0] <= extbus_d_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            a_pipe[i] <= a_pipe[i-1];
            d_pipe[i] <= d_pipe[i-1];
         end
      end
   end

   assign cs_s  = cs_sync[SYNC_STAGES-1];
   assign rd_s  = rd_sync[SYNC_STAGES-1];
   assign wr_s  = wr_sync[SYNC_STAGES-1];
   assign vld_s = vld_sync[SYNC_STAGES-1];
   assign a_s   = a_pipe[SYNC_STAGES-1];
   assign d_s   = d_pipe[SYNC_STAGES-1];

   // Both strobes low together selects neither direction.
   assign sel_wr     = !cs_s & !wr_s & rd_s;
   assign sel_rd     = !cs_s & !rd_s & wr_s;
   assign bus_idle_s = cs_s | (rd_s & wr_s);

   assign state_dbg = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         armed        <= 1'b0;
         hold_a       <= '0;
         hold_d       <= '0;
         lookup_addr  <= '0;
         reg_addr     <= '0;
         reg_wrdata   <= '0;
         extbus_d_out <= '0;
         reg_wr       <= 1'b0;
         reg_rd_done  <= 1'b0;
      end else begin
         reg_wr      <= 1'b0;
         reg_rd_done <= 1'b0;
         // A new access may start only after a genuinely idle bus has been
         // observed since reset.
         if (vld_s & bus_idle_s)
            armed <= 1'b1;
         case (state)
            IDLE: begin
               if (armed & sel_wr) begin
                  state  <= WRITE;
                  hold_a <= a_s;
                  hold_d <= d_s;
               end else if (armed & sel_rd) begin
                  state       <= READ;
                  lookup_addr <= a_s;
                  hold_a      <= a_s;
               end
            end
            WRITE: begin
               // Keep re-capturing so late-valid data is what commits.
               if (sel_wr) begin
                  hold_a <= a_s;
                  hold_d <= d_s;
               end else begin
                  state      <= IDLE;
                  reg_wr     <= 1'b1;
                  reg_addr   <= hold_a;
                  reg_wrdata <= hold_d;
               end
            end
            READ: begin
               if (sel_rd) begin
                  lookup_addr  <= a_s;
                  hold_a       <= a_s;
                  extbus_d_out <= reg_rddata;
               end else begin
                  state       <= IDLE;
                  reg_rd_done <= 1'b1;
                  reg_addr    <= hold_a;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_extbus_responder.sv
module tb_extbus_responder;

   localparam int SYNC = 2;
   localparam int AW   = 5;
   localparam int W    = 1 + AW + 8;   // {is_read, addr, data}

   logic          clk;
   logic          rst;
   logic          extbus_cs_n, extbus_rd_n, extbus_wr_n;
   logic [AW-1:0] extbus_a;
   logic [7:0]    extbus_d_in;
   logic [7:0]    extbus_d_out;
   logic          extbus_d_oe;
   logic [AW-1:0] lookup_addr;
   logic [7:0]    reg_rddata;
   logic          reg_wr, reg_rd_done;
   logic [AW-1:0] reg_addr;
   logic [7:0]    reg_wrdata;
   logic [1:0]    state_dbg;

   logic [7:0]    regs [32];
   logic [W-1:0]  exp_q [$];
   int            checks = 0;
   int            errors = 0;

   extbus_responder #(.SYNC_STAGES(SYNC), .ADDR_W(AW)) dut (
      .clk          (clk),
      .rst          (rst),
      .extbus_cs_n  (extbus_cs_n),
      .extbus_rd_n  (extbus_rd_n),
      .extbus_wr_n  (extbus_wr_n),
      .extbus_a     (extbus_a),
      .extbus_d_in  (extbus_d_in),
      .extbus_d_out (extbus_d_out),
      .extbus_d_oe  (extbus_d_oe),
      .lookup_addr  (lookup_addr),
      .reg_rddata   (reg_rddata),
      .reg_wr       (reg_wr),
      .reg_rd_done  (reg_rd_done),
      .reg_addr     (reg_addr),
      .reg_wrdata   (reg_wrdata),
      .state_dbg    (state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #20 clk = ~clk;   // 25 MHz

   assign reg_rddata = regs[lookup_addr];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- scoreboard / monitor ----------------
   always @(posedge clk) begin
      #1;
      check("oe_pins", extbus_d_oe, !extbus_cs_n & !extbus_rd_n & extbus_wr_n);
      check("pulse_excl", reg_wr & reg_rd_done, 1'b0);
      if (reg_wr | reg_rd_done) begin
         check("sb_nonempty", exp_q.size() != 0, 1'b1);
         if (exp_q.size() != 0)
            check("pulse", {reg_rd_done, reg_addr, (reg_rd_done ? extbus_d_out : reg_wrdata)},
                  exp_q.pop_front());
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout at %0t", $time);
      $fatal(1, "timeout");
   end

   // ---------------- driver tasks ----------------
   task automatic bus_gap(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_write(input logic [AW-1:0] a, input logic [7:0] d, input int low_cyc);
      exp_q.push_back({1'b0, a, d});
      @(negedge clk);
      extbus_a = a; extbus_d_in = d; extbus_cs_n = 1'b0;
      @(negedge clk);
      extbus_wr_n = 1'b0;
      repeat (low_cyc) @(negedge clk);
      extbus_wr_n = 1'b1;
      @(negedge clk);
      extbus_cs_n = 1'b1;
      bus_gap(SYNC + 3);
   endtask

   task automatic bus_read(input logic [AW-1:0] a, input int low_cyc, input logic chk_data);
      exp_q.push_back({1'b1, a, regs[a]});
      @(negedge clk);
      extbus_a = a; extbus_cs_n = 1'b0;
      @(negedge clk);
      extbus_rd_n = 1'b0;
      repeat (low_cyc) @(negedge clk);
      if (chk_data) begin
         check("rd_data_early", extbus_d_out, regs[a]);
         check("rd_oe_on", extbus_d_oe, 1'b1);
      end
      extbus_rd_n = 1'b1;
      #1;
      if (chk_data) check("rd_oe_off", extbus_d_oe, 1'b0);
      @(negedge clk);
      extbus_cs_n = 1'b1;
      bus_gap(SYNC + 3);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1;
      extbus_cs_n = 1'b1; extbus_rd_n = 1'b1; extbus_wr_n = 1'b1;
      extbus_a = '0; extbus_d_in = '0;
      for (int i = 0; i < 32; i++) regs[i] = 8'($urandom_range(0, 255));
      regs[4] = 8'hA1;

      repeat (3) @(posedge clk);
      #1;
      check("rst_reg_wr", reg_wr, 1'b0);
      check("rst_rd_done", reg_rd_done, 1'b0);
      check("rst_reg_addr", reg_addr, 0);
      check("rst_wrdata", reg_wrdata, 0);
      check("rst_d_out", extbus_d_out, 0);
      check("rst_lookup", lookup_addr, 0);
      check("rst_state", state_dbg, 0);
      @(negedge clk);
      rst = 1'b0;
      bus_gap(SYNC + 3);

      // 8 MHz phi2 write: data valid 25 ns into a ~62 ns strobe, latency check
      exp_q.push_back({1'b0, 5'd5, 8'h01});
      @(negedge clk);
      extbus_a = 5'd5; extbus_d_in = 8'hFF; extbus_cs_n = 1'b0;
      @(posedge clk);
      #5  extbus_wr_n = 1'b0;
      #25 extbus_d_in = 8'h01;
      #37 extbus_wr_n = 1'b1;
      #10 begin extbus_cs_n = 1'b1; extbus_d_in = 8'h00; end
      for (int k = 1; k <= SYNC + 3; k++) begin
         @(posedge clk);
         #1;
         check("wr_latency", reg_wr, (k == SYNC + 1));
      end
      bus_gap(SYNC + 2);

      // four back-to-back writes to one address
      bus_write(5'd4, 8'hA2 - 8'h01, 2);
      bus_write(5'd4, 8'hA2, 3);
      bus_write(5'd4, 8'hA3, 1);
      bus_write(5'd4, 8'hA4, 2);

      // read of address 4 held long enough for data before rd_n rises
      bus_read(5'd4, SYNC + 3, 1'b1);

      // strobes toggled with chip select inactive
      @(negedge clk);
      extbus_a = '0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); extbus_wr_n = 1'b0;
         @(negedge clk); extbus_wr_n = 1'b1; extbus_rd_n = 1'b0;
         #1 check("cs_off_oe", extbus_d_oe, 1'b0);
         @(negedge clk); extbus_rd_n = 1'b1;
         check("cs_off_state", state_dbg, 0);
      end
      bus_gap(SYNC + 3);

      // reset in the middle of a write: that access must be dropped
      @(negedge clk);
      extbus_a = 5'd2; extbus_d_in = 8'h55; extbus_cs_n = 1'b0;
      @(negedge clk); extbus_wr_n = 1'b0;
      bus_gap(SYNC + 3);
      check("pre_rst_state", state_dbg, 1);
      rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      bus_gap(SYNC + 4);
      check("post_rst_state", state_dbg, 0);
      extbus_wr_n = 1'b1;
      @(negedge clk); extbus_cs_n = 1'b1;
      bus_gap(SYNC + 3);
      bus_write(5'd2, 8'h66, 2);

      // both strobes low together: ignored
      @(negedge clk);
      extbus_a = 5'd7; extbus_cs_n = 1'b0;
      @(negedge clk); extbus_rd_n = 1'b0; extbus_wr_n = 1'b0;
      for (int i = 0; i < SYNC + 4; i++) begin
         @(negedge clk);
         check("both_low_state", state_dbg, 0);
      end
      extbus_rd_n = 1'b1; extbus_wr_n = 1'b1;
      @(negedge clk); extbus_cs_n = 1'b1;
      bus_gap(SYNC + 3);

      // randomised mix of accesses
      for (int i = 0; i < 12; i++) begin
         if ($urandom_range(0, 1) == 0)
            bus_write(AW'($urandom_range(0, 31)), 8'($urandom_range(0, 255)), $urandom_range(1, 4));
         else
            bus_read(AW'($urandom_range(0, 31)), $urandom_range(SYNC + 2, SYNC + 4), 1'b0);
      end

      bus_gap(SYNC + 6);
      check("sb_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
